// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART message controller slice.
//   state_e  : controller state encoding (IDLE, BANNER, GAP, ECHO)
//   BYTE_W   : width of one UART byte
//   ASCII_CR : carriage return, ASCII_LF : line feed (common banner terminators)
//   timer_tc : terminal count of the banner repeat timer
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0d;
    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0a;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BANNER = 2'd1,
        GAP    = 2'd2,
        ECHO   = 2'd3
    } state_e;

    // Last timer value of one repeat period (period length in cycles minus one).
    function automatic int timer_tc(input int clk_fre_mhz, input int period_ms);
        return clk_fre_mhz * 1000 * period_ms - 1;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_byte_fifo
// Synchronous byte FIFO buffering received bytes for the echo path.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only if a pop happens in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data
//   pop, dout  : read strobe and head-of-queue data (valid while !empty)
//   full, empty: occupancy status
// ---------------------------------------------------------------------------
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              wr_en;
    logic              rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_msg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_msg_ctrl
// Byte-level message controller between uart_rx and uart_tx. Sends a
// loadable banner every PERIOD_MS (measured from the end of the previous
// banner) and echoes received bytes through a FIFO so nothing arriving
// mid-banner is lost.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable, echo_en   : banner generation enable, echo path enable
//   msg_data, msg_len : banner bytes (byte 0 in the MSBs) and length
//   rx_data, rx_valid : received byte and one-cycle strobe
//   tx_data, tx_valid, tx_ready : valid/ready byte offer to uart_tx
//   ovf, ovf_clr      : sticky echo-FIFO overflow flag and its clear
//   busy              : banner in progress or a byte is on offer
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; enable starts a banner, else drain echo FIFO
// BANNER | sending latched banner bytes 0..len-1
// GAP    | repeat timer running; echo bytes may be sent
// ECHO   | one popped echo byte on offer until accepted
// ---------------------------------------------------------------------------
module uart_msg_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 27,
    parameter int PERIOD_MS  = 1000,
    parameter int MSG_MAX    = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = $clog2(MSG_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      echo_en,
    input  logic [MSG_MAX*BYTE_W-1:0] msg_data,
    input  logic [LEN_W-1:0]          msg_len,
    input  logic [BYTE_W-1:0]         rx_data,
    input  logic                      rx_valid,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      ovf,
    input  logic                      ovf_clr,
    output logic                      busy
);

    localparam int TMR_W = $clog2(CLK_FRE * 1000 * PERIOD_MS);
    localparam logic [TMR_W-1:0] TMR_TC = TMR_W'(timer_tc(CLK_FRE, PERIOD_MS));
    localparam int IDX_W = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;

    state_e            state_q;
    logic              tx_valid_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic [BYTE_W-1:0] msg_q [MSG_MAX];
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_clamp_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [TMR_W-1:0]  timer_q;
    logic [TMR_W-1:0]  timer_d;
    logic              sent_q;
    logic              enable_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              last_byte;

    logic              fifo_push;
    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    assign len_clamp_d = (msg_len > LEN_W'(MSG_MAX)) ? LEN_W'(MSG_MAX) : msg_len;
    assign last_byte   = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
    assign idx_d       = idx_q + IDX_W'(1);
    // Saturating so an expiry reached while an echo is on offer is still seen in GAP.
    assign timer_d     = (timer_q == TMR_TC) ? timer_q : timer_q + TMR_W'(1);

    // Pop only where the FSM moves to ECHO; the popped head is loaded into
    // tx_data on the same edge.
    always_comb begin
        fifo_pop = 1'b0;
        if (echo_en && !fifo_empty) begin
            if (state_q == IDLE && !enable)
                fifo_pop = 1'b1;
            if (state_q == GAP && enable && timer_q != TMR_TC)
                fifo_pop = 1'b1;
        end
    end

    assign fifo_push = rx_valid && echo_en;
    // A pop in the same cycle frees a slot, so a push while full is not an overflow then.
    assign ovf_d     = (fifo_push && fifo_full && !fifo_pop) || (ovf_q && !ovf_clr);

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            sent_q     <= 1'b0;
            enable_q   <= 1'b0;
            for (int i = 0; i < MSG_MAX; i++) msg_q[i] <= '0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) sent_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < MSG_MAX; i++)
                            msg_q[i] <= msg_data[(MSG_MAX-1-i)*BYTE_W +: BYTE_W];
                        len_q   <= len_clamp_d;
                        idx_q   <= '0;
                        state_q <= BANNER;
                    end else if (fifo_pop) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= fifo_dout;
                        state_q    <= ECHO;
                    end
                end

                BANNER: begin
                    if (!tx_valid_q) begin
                        if (!enable) begin
                            state_q <= IDLE;
                        end else if (len_q == '0) begin
                            timer_q <= '0;
                            sent_q  <= 1'b1;
                            state_q <= GAP;
                        end else begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= msg_q[idx_q];
                        end
                    end else if (tx_ready) begin
                        if (!enable) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end else if (last_byte) begin
                            tx_valid_q <= 1'b0;
                            timer_q    <= '0;
                            sent_q     <= 1'b1;
                            state_q    <= GAP;
                        end else begin
                            idx_q     <= idx_d;
                            tx_data_q <= msg_q[idx_d];
                        end
                    end
                end

                GAP: begin
                    timer_q <= timer_d;
                    if (!enable || timer_q == TMR_TC) begin
                        state_q <= IDLE;
                    end else if (fifo_pop) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= fifo_dout;
                        state_q    <= ECHO;
                    end
                end

                ECHO: begin
                    timer_q <= timer_d;
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= sent_q ? GAP : IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q == BANNER) || tx_valid_q;

endmodule

// File: tb/tb_uart_msg_ctrl.sv
module tb_uart_msg_ctrl;
    import uart_pkg::*;

    localparam int MSG_MAX = 8;
    localparam int LEN_W   = 4;
    localparam int PERIOD  = 1 * 1000 * 1;

    logic                   clk      = 1'b0;
    logic                   rst_n    = 1'b0;
    logic                   enable   = 1'b0;
    logic                   echo_en  = 1'b0;
    logic [MSG_MAX*8-1:0]   msg_data = '0;
    logic [LEN_W-1:0]       msg_len  = '0;
    logic [7:0]             rx_data  = '0;
    logic                   rx_valid = 1'b0;
    logic                   tx_ready = 1'b0;
    logic                   ovf_clr  = 1'b0;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   ovf;
    logic                   busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_mode = 0;       // 0: always ready, 1: random, 2: never ready
    int valid_cycles = 0;
    int en_cyc = 0;
    int blen = 0;

    logic [7:0] acc_b[$];     // accepted bytes in order
    int         acc_e[$];     // edge number of each acceptance
    int         app_e[$];     // edge after which each accepted byte first appeared
    logic [7:0] exp_q[$];     // reference byte stream
    logic [7:0] ref_msg [MSG_MAX];

    logic       cur_open  = 1'b0;
    int         cur_app   = 0;
    logic [7:0] hold_data = '0;

    uart_msg_ctrl #(
        .CLK_FRE    (1),
        .PERIOD_MS  (1),
        .MSG_MAX    (MSG_MAX),
        .FIFO_DEPTH (4),
        .LEN_W      (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .echo_en  (echo_en),
        .msg_data (msg_data),
        .msg_len  (msg_len),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // tx side: drive tx_ready, check hold-while-stalled, record acceptances
    always @(negedge clk) begin
        case (ready_mode)
            0:       tx_ready = 1'b1;
            2:       tx_ready = 1'b0;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (!rst_n) begin
            cur_open = 1'b0;
        end else begin
            if (cur_open) begin
                chk("hold_valid", 32'(tx_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(hold_data));
            end
            if (tx_valid === 1'b1) begin
                valid_cycles++;
                chk("busy_with_valid", 32'(busy), 1);
                if (!cur_open) begin
                    cur_open  = 1'b1;
                    cur_app   = cyc;
                    hold_data = tx_data;
                end
                if (tx_ready) begin
                    acc_b.push_back(tx_data);
                    acc_e.push_back(cyc + 1);
                    app_e.push_back(cur_app);
                    cur_open = 1'b0;
                end
            end else begin
                cur_open = 1'b0;
            end
        end
    end

    function automatic int span(input int acc_idx, input int app_idx);
        if (acc_idx < acc_e.size() && app_idx < app_e.size())
            return app_e[app_idx] - acc_e[acc_idx];
        return -1;
    endfunction

    task automatic clear_log();
        acc_b.delete(); acc_e.delete(); app_e.delete(); exp_q.delete();
        valid_cycles = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        enable = 1'b0; rx_valid = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        clear_log();
        #2 rst_n = 1'b1;
    endtask

    task automatic set_msg(input int len);
        for (int i = 0; i < MSG_MAX; i++) msg_data[(MSG_MAX-1-i)*8 +: 8] = ref_msg[i];
        msg_len = LEN_W'(len);
    endtask

    task automatic add_banner(input int len);
        int n;
        n = (len > MSG_MAX) ? MSG_MAX : len;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_msg[i]);
    endtask

    task automatic hi_msg();
        for (int i = 0; i < MSG_MAX; i++) ref_msg[i] = 8'($urandom);
        ref_msg[0] = 8'h48; ref_msg[1] = 8'h69; ref_msg[2] = ASCII_CR; ref_msg[3] = ASCII_LF;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic clr);
        rx_valid = 1'b1; rx_data = b; ovf_clr = clr;
        @(negedge clk);
        rx_valid = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int k = 0;
        while (acc_b.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(acc_b.size() >= n), 1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int k = 0;
        while (tx_valid !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(tx_valid), 1);
    endtask

    task automatic check_stream(input string tag);
        int n;
        chk({tag, "_count"}, acc_b.size(), exp_q.size());
        n = (acc_b.size() < exp_q.size()) ? acc_b.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), 32'(acc_b[i]), 32'(exp_q[i]));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_busy", 32'(busy), 0);

        // 1: "Hi\r\n" with constant ready, latency and period
        hi_msg(); set_msg(4); ready_mode = 0; echo_en = 1'b1;
        do_reset();
        @(negedge clk); enable = 1'b1; en_cyc = cyc;
        add_banner(4); add_banner(4);
        wait_acc(8, 3000, "t1_wait");
        check_stream("t1");
        chk("t1_latency", (app_e.size() > 0) ? app_e[0] - en_cyc : -1, 2);
        chk("t1_period", span(3, 4), PERIOD + 2);
        repeat (10) @(negedge clk);
        chk("t1_gap_busy", 32'(busy), 0);

        // 2: random message, random ready, random echo bytes in the gaps
        for (int i = 0; i < MSG_MAX; i++) ref_msg[i] = 8'($urandom);
        blen = $urandom_range(1, MSG_MAX);
        set_msg(blen); ready_mode = 1;
        do_reset();
        @(negedge clk); enable = 1'b1;
        for (int b = 0; b < 3; b++) begin
            add_banner(blen);
            wait_acc(exp_q.size(), 3000, "t2_wait");
            if (b < 2) begin
                for (int e = 0; e < 2; e++) begin
                    logic [7:0] r;
                    r = 8'($urandom);
                    exp_q.push_back(r);
                    rx_byte(r, 1'b0);
                end
                wait_acc(exp_q.size(), 200, "t2_echo_wait");
            end
        end
        check_stream("t2");
        chk("t2_period", span(blen - 1, blen + 2), PERIOD + 2);

        // 3: bytes arriving mid-banner are echoed after it, period unchanged
        hi_msg(); set_msg(4); ready_mode = 0;
        do_reset();
        @(negedge clk); enable = 1'b1;
        wait_valid(20, "t3_start");
        rx_byte(8'h41, 1'b0); rx_byte(8'h42, 1'b0); rx_byte(8'h43, 1'b0);
        add_banner(4); exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        add_banner(4);
        wait_acc(11, 3000, "t3_wait");
        check_stream("t3");
        chk("t3_period", span(3, 7), PERIOD + 2);

        // 4: overflow, clear, and clear coinciding with a new overflow
        ready_mode = 2;
        do_reset();
        @(negedge clk); enable = 1'b1;
        wait_valid(20, "t4_start");
        for (int i = 0; i < 6; i++) rx_byte(8'h50 + 8'(i), 1'b0);
        chk("t4_ovf_set", 32'(ovf), 1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(ovf), 0);
        ready_mode = 0;
        add_banner(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h50 + 8'(i));
        wait_acc(8, 200, "t4_wait1");
        ready_mode = 2;
        wait_valid(1500, "t4_start2");
        for (int i = 0; i < 4; i++) rx_byte(8'h60 + 8'(i), 1'b0);
        rx_byte(8'h64, 1'b1);
        chk("t4_ovf_clr_collide", 32'(ovf), 1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        chk("t4_ovf_clr2", 32'(ovf), 0);
        ready_mode = 0;
        add_banner(4);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
        wait_acc(16, 200, "t4_wait2");
        check_stream("t4");

        // 5: zero length sends nothing, oversize length is clamped
        set_msg(0);
        do_reset();
        @(negedge clk); enable = 1'b1;
        repeat (2500) @(negedge clk);
        chk("t5_len0_valid", valid_cycles, 0);
        for (int i = 0; i < MSG_MAX; i++) ref_msg[i] = 8'($urandom);
        set_msg(12);
        do_reset();
        @(negedge clk); enable = 1'b1;
        add_banner(12);
        repeat (500) @(negedge clk);
        check_stream("t5_clamp");

        // 6: reset in the middle of an offered byte
        hi_msg(); set_msg(4); ready_mode = 2;
        do_reset();
        @(negedge clk); enable = 1'b1;
        wait_valid(20, "t6_start");
        rx_byte(8'h77, 1'b0); rx_byte(8'h78, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(tx_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        #2 rst_n = 1'b1;
        ready_mode = 0;
        repeat (30) @(negedge clk);
        chk("t6_fifo_empty", valid_cycles, 0);
        enable = 1'b1;
        add_banner(4);
        wait_acc(4, 50, "t6_wait");
        check_stream("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_msg_ctrl.md
Name: uart_msg_ctrl

Overview:
Byte-level message controller that sits between the existing uart_rx and uart_tx PHY instances in the UART top level.
- Transmits a parametrised, runtime-loadable banner string every PERIOD_MS.
- Echoes every received byte through a receive FIFO, so bytes arriving mid-banner are buffered, not lost.
- Reports FIFO overflow and a busy status to the top level.

Parameters:
CLK_FRE, 27, clock frequency in MHz.
PERIOD_MS, 1000, banner repeat interval in ms, measured from the end of the previous banner.
MSG_MAX, 32, maximum banner length in bytes.
FIFO_DEPTH, 16, echo FIFO entries; must be a power of 2, minimum 2.
LEN_W, $clog2(MSG_MAX+1), width of the msg_len port.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
enable  in  1  banner generation enable
echo_en  in  1  echo path enable
msg_data  in  MSG_MAX*8  banner bytes; byte i is at [(MSG_MAX-1-i)*8 +: 8], so byte 0 is the MSBs
msg_len  in  LEN_W  banner length in bytes
rx_data  in  8  byte from uart_rx
rx_valid  in  1  one-cycle strobe: rx_data is valid
tx_data  out  8  byte to uart_tx
tx_valid  out  1  byte offer to uart_tx
tx_ready  in  1  uart_tx accepts the byte when tx_valid && tx_ready
ovf  out  1  sticky echo-FIFO overflow flag
ovf_clr  in  1  clears ovf
busy  out  1  high in state BANNER, or whenever tx_valid is high

Behaviour:
Reset (asynchronous, rst_n low):
- tx_valid=0, tx_data=0, ovf=0, busy=0.
- FIFO empty, timer=0, state=IDLE.

Transmit handshake:
- tx_data must not change while tx_valid=1 and tx_ready=0.
- tx_valid drops, or the next byte is presented, in the cycle after acceptance.
- Back-to-back: a new byte may be presented in the cycle immediately after acceptance.

States:
- IDLE: if enable, latch msg_data and min(msg_len, MSG_MAX) and go to BANNER. Else, if echo_en and FIFO not empty, go to ECHO.
- BANNER:
  - Present latched bytes 0..len-1 in order, advancing the index on each acceptance.
  - After the last byte is accepted: tx_valid=0, timer=0, go to GAP.
  - A latched len of 0 goes straight to GAP with no tx_valid pulse.
- GAP:
  - Timer increments every cycle.
  - When timer reaches CLK_FRE*1000*PERIOD_MS-1 and no echo byte is outstanding, go to IDLE.
  - Otherwise, if echo_en and FIFO not empty, pop the head and go to ECHO. The timer keeps counting during ECHO.
- ECHO:
  - Present the popped byte; hold until accepted.
  - On acceptance, return to GAP if a banner has been sent since the last enable rise, else to IDLE.

Timer:
- Width $clog2(CLK_FRE*1000*PERIOD_MS).
- Saturates at its terminal value, so an expiry during ECHO is honoured on return to GAP.

Echo FIFO:
- Write when rx_valid && echo_en, in every state.
- Write while full: byte dropped, ovf=1.
- Simultaneous push and pop when full: both succeed, no overflow.
- ovf_clr and a new overflow in the same cycle: ovf stays 1.

Priority:
- A byte already offered (tx_valid=1) always completes before any state change.
- The banner is never interrupted by echo.

enable deasserted:
- Mid-BANNER: the current byte completes, then go to IDLE, remainder discarded.
- In GAP: return to IDLE; echo continues from IDLE.

echo_en deasserted: FIFO contents are retained and drained later.

msg_len > MSG_MAX: clamped to MSG_MAX.

msg_data/msg_len changes during BANNER: no effect until the next latch.

First banner after reset: starts on the first cycle enable=1, with 2-cycle latency from IDLE to the first tx_valid.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, BANNER, GAP, ECHO
  - BYTE_W=8
  - ASCII_CR=8'h0d, ASCII_LF=8'h0a
  - function for the timer terminal count
- Sub-module uart_byte_fifo: synchronous FIFO, parameter DEPTH; ports push/pop/din/dout/full/empty; one extra pointer bit for full/empty.

Test Plan:
(Use CLK_FRE=1, PERIOD_MS=1, so the period is 1000 cycles; MSG_MAX=8; FIFO_DEPTH=4.)
1. msg "Hi\r\n", len=4, tx_ready=1 constant, enable=1 -> bytes 0x48,0x69,0x0d,0x0a in order. Next 0x48 appears exactly 1000+2 cycles after the 0x0a acceptance.
2. tx_ready toggled randomly -> tx_data stable while stalled; no byte duplicated or skipped over 3 banners.
3. Inject 0x41,0x42,0x43 via rx_valid during BANNER -> banner completes intact, then 0x41,0x42,0x43 echoed in GAP; timer period unchanged.
4. 6 rx bytes during BANNER with FIFO_DEPTH=4 -> first 4 echoed, ovf=1. ovf_clr -> ovf=0. Same-cycle ovf_clr plus overflow -> ovf=1.
5. msg_len=0 -> no tx_valid for banners. msg_len=12 -> exactly 8 bytes sent.
6. rst_n low mid-byte in BANNER -> tx_valid=0 immediately and FIFO empty. After release, the banner restarts from byte 0.
